// File: rtl/param_readback_tx.sv
// ---------------------------------------------------------------------------
// param_readback_tx
// Reports the active pulse-sequencer parameter set back to the LabView host
// as a 19-byte frame of 8N1 UART characters on txd. A send strobe copies all
// field inputs into a shadow register, and the frame is built from that copy.
//
// Frame: SYNC, {6'b0,bl,pu}, per[3], p1wid[2], del[2], p2wid[2], nut_w,
//        nut_d[2], cp, p_bl, p_bl_off[2], checksum (8-bit sum of bytes 1..17)
//        Multi-byte fields go out MSB byte first; bits go out LSB first.
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   send_i         one-cycle frame request (queued one deep while busy)
//   pu_i .. p_bl_off_i  parameter fields to report
//   txd_o          UART serial out, idle high
//   busy_o         high while a frame is in flight or pending
//   frame_done_o   one-cycle pulse the cycle after the last stop bit
// ---------------------------------------------------------------------------
module param_readback_tx #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        send_i,
    input  logic        pu_i,
    input  logic        bl_i,
    input  logic [23:0] per_i,
    input  logic [15:0] p1wid_i,
    input  logic [15:0] del_i,
    input  logic [15:0] p2wid_i,
    input  logic [7:0]  nut_w_i,
    input  logic [15:0] nut_d_i,
    input  logic [7:0]  cp_i,
    input  logic [7:0]  p_bl_i,
    input  logic [15:0] p_bl_off_i,
    output logic        txd_o,
    output logic        busy_o,
    output logic        frame_done_o
);

    // state   | meaning
    // S_IDLE  | line idle high, waiting for send
    // S_START | driving the start bit of the current byte
    // S_DATA  | shifting out data bits, LSB first
    // S_STOP  | driving the stop bit; chooses next byte / frame end
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [4:0]        LAST_BYTE = 5'd18;
    localparam int                FIELD_W   = 136;  // bytes 1..17

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           bit_q, bit_d;
    logic [4:0]           byte_q, byte_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           csum_q, csum_d;
    logic                 pending_q, pending_d;
    logic [FIELD_W-1:0]   shadow_q;
    logic                 txd_q, txd_d;
    logic                 busy_q;
    logic                 frame_done_q;

    logic                 tc;
    logic                 start_frame;
    logic                 frame_end;
    logic [4:0]           nxt_idx;
    logic [7:0]           nxt_byte;
    logic [FIELD_W-1:0]   field_bus;

    // Byte 1 sits in the top of the bus so byte k is a fixed slice.
    assign field_bus = {6'b0, bl_i, pu_i, per_i, p1wid_i, del_i, p2wid_i,
                        nut_w_i, nut_d_i, cp_i, p_bl_i, p_bl_off_i};

    function automatic logic [7:0] field_byte(input logic [FIELD_W-1:0] bus,
                                              input logic [4:0]         idx);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < 17; k++) begin
            if (idx == 5'(k + 1)) r = bus[(16 - k) * 8 +: 8];
        end
        return r;
    endfunction

    assign tc = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        shift_d     = shift_q;
        csum_d      = csum_q;
        pending_d   = pending_q;
        start_frame = 1'b0;
        frame_end   = 1'b0;
        txd_d       = 1'b1;
        nxt_idx     = byte_q + 5'd1;
        nxt_byte    = (nxt_idx == LAST_BYTE) ? csum_q : field_byte(shadow_q, nxt_idx);

        if (!tc) cnt_d = cnt_q - CNT_W'(1);

        case (state_q)
            S_IDLE: begin
                if (send_i) start_frame = 1'b1;
            end
            S_START: begin
                if (tc) begin
                    state_d = S_DATA;
                    cnt_d   = CNT_LOAD;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (tc) begin
                    cnt_d = CNT_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                    end
                end
            end
            S_STOP: begin
                if (tc) begin
                    if (byte_q == LAST_BYTE) begin
                        frame_end = 1'b1;
                        // A send landing on this cycle counts as pending.
                        if (pending_q || send_i) start_frame = 1'b1;
                        else                     state_d     = S_IDLE;
                    end else begin
                        state_d = S_START;
                        cnt_d   = CNT_LOAD;
                        byte_d  = nxt_idx;
                        shift_d = nxt_byte;
                        // Checksum tracks bytes 1..17 as they are loaded, so it
                        // is complete by the time byte 18 is selected.
                        if (nxt_idx != LAST_BYTE) csum_d = csum_q + nxt_byte;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (start_frame) begin
            state_d   = S_START;
            cnt_d     = CNT_LOAD;
            bit_d     = 3'd0;
            byte_d    = 5'd0;
            shift_d   = SYNC_BYTE;
            csum_d    = 8'h00;
            pending_d = 1'b0;
        end else if (send_i && state_q != S_IDLE) begin
            pending_d = 1'b1;
        end

        // txd is registered, so it is derived from the upcoming state.
        case (state_d)
            S_START: txd_d = 1'b0;
            S_DATA:  txd_d = shift_d[0];
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= 3'd0;
            byte_q       <= 5'd0;
            shift_q      <= 8'h00;
            csum_q       <= 8'h00;
            pending_q    <= 1'b0;
            shadow_q     <= '0;
            txd_q        <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            byte_q       <= byte_d;
            shift_q      <= shift_d;
            csum_q       <= csum_d;
            pending_q    <= pending_d;
            txd_q        <= txd_d;
            busy_q       <= (state_d != S_IDLE);
            frame_done_q <= frame_end;
            if (start_frame) shadow_q <= field_bus;
        end
    end

    assign txd_o        = txd_q;
    assign busy_o       = busy_q;
    assign frame_done_o = frame_done_q;

endmodule
